multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS core. Sequences fetch, decode, execute, memory and writeback phases from the instruction opcode, and drives every datapath enable and mux select. It also drives the 2-bit OpALU code consumed by the ULAControl block. Memory phases stall on a ready handshake.

## Interface
- No parameters. Opcodes are fixed: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- pc_en  out  1  PCWrite | (PCWriteCond & zero)
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
- ALUSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
- OpALU  out  2  00 add, 01 sub, 10 use funct (to ULAControl)
- illegal  out  1  one-cycle flag for an unsupported opcode
- state  out  4  current state, for debug and the bench

## Operation
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXEC 6, RWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11
  - Codes 12–15 go to FETCH on the next edge, with all outputs 0.
- Transitions:
  - FETCH → DECODE when mem_ready=1; otherwise stay in FETCH.
  - DECODE → MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi), JUMP (j).
  - DECODE → FETCH for any other opcode, with illegal=1 during that DECODE cycle.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB when mem_ready=1; otherwise stay.
  - MEMWRITE → FETCH when mem_ready=1; otherwise stay.
  - EXEC → RWB; ADDIEX → ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH, JUMP → FETCH.
- Outputs are decoded from state. Any signal not listed for a state is 0.
  - FETCH: MemRead=1, ALUSrcB=01. IRWrite and PCWrite equal mem_ready (Mealy), so PC advances exactly once per fetch.
  - DECODE: ALUSrcB=11 (branch target precomputed).
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - MEMREAD: MemRead=1, IorD=1.
  - MEMWRITE: MemWrite=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - EXEC: ALUSrcA=1, OpALU=10.
  - RWB: RegWrite=1, RegDst=1.
  - ADDIWB: RegWrite=1.
  - BRANCH: ALUSrcA=1, OpALU=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
- OpALU is 00 in every state except EXEC (10) and BRANCH (01).

## Timing
- State register updates on the rising edge of clk.
- Reset:
  - With reset=1 at an edge, the state becomes FETCH. Reset overrides every other condition, including mid-instruction and mid-stall.
  - While reset is high, all outputs are forced to 0, including pc_en, illegal and state.
  - The first FETCH is active in the cycle after reset deasserts.
- Cycles per instruction with mem_ready held at 1 (FETCH through final state, inclusive):
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
  - Outputs hold constant during the stall, except IRWrite and PCWrite in FETCH, which stay 0 until mem_ready rises.
- pc_en is combinational. In BRANCH it follows zero within the same cycle.
- opcode is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

## Test plan
- Reset and stall:
  - Stimulus: reset=1 for 2 cycles, then release with mem_ready=0 for 3 cycles, then mem_ready=1.
  - Required: state=0 and all outputs 0 during reset. State stays 0 with MemRead=1, IRWrite=0, PCWrite=0 for 3 cycles. IRWrite=pc_en=1 in the ready cycle, and state=1 on the next cycle.
- R-type sequence:
  - Stimulus: opcode=000000, mem_ready=1.
  - Required: state 0→1→6→7→0. OpALU=10 only in state 6. RegWrite=1 and RegDst=1 in state 7.
- lw with memory wait:
  - Stimulus: opcode=100011, mem_ready low for 2 cycles in MEMREAD.
  - Required: state 0→1→2→3→3→3→4→0. IorD=1 in state 3. MemtoReg=1 and RegWrite=1 in state 4.
- sw:
  - Stimulus: opcode=101011.
  - Required: state 0→1→2→5→0. MemWrite=1 and IorD=1 in state 5. RegWrite never asserted.
- beq and j:
  - Stimulus: beq with zero=1, then beq with zero=0, then j.
  - Required for beq zero=1: in state 8, pc_en=1, PCSource=01, OpALU=01.
  - Required for beq zero=0: in state 8, pc_en=0.
  - Required for j: in state 11, pc_en=1, PCSource=10. Each instruction returns to state 0.
- Illegal opcode and reset mid-operation:
  - Stimulus: opcode=111111; separately, assert reset while in state 3.
  - Required for opcode 111111: illegal=1 in state 1 only, next state 0.
  - Required for reset in state 3: state=0 on the next edge, and all outputs 0 while reset is high.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback from the opcode and drives every datapath control.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       pc_en,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] OpALU,
  output logic       illegal,
  output logic [3:0] state
);

  // state | meaning
  // FETCH    | read instruction, PC+4 (waits on mem_ready)
  // DECODE   | register read, branch target precompute
  // MEMADR   | lw/sw effective address
  // MEMREAD  | data read (waits on mem_ready)
  // MEMWB    | load writeback
  // MEMWRITE | data write (waits on mem_ready)
  // EXEC     | R-type ALU operation
  // RWB      | R-type writeback
  // BRANCH   | beq compare and conditional PC update
  // ADDIEX   | addi ALU operation
  // ADDIWB   | addi writeback
  // JUMP     | jump target to PC
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC     = 4'd6,
    RWB      = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    OpALU       = 2'b00;
    illegal     = 1'b0;
    // Reset masks every output, including the Mealy terms in FETCH.
    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          unique case (opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_R:         state_d = EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_ADDI:      state_d = ADDIEX;
            OP_J:         state_d = JUMP;
            default: begin
              state_d = FETCH;
              illegal = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (opcode == OP_LW)      state_d = MEMREAD;
          else if (opcode == OP_SW) state_d = MEMWRITE;
          else                      state_d = FETCH;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? MEMWB : MEMREAD;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          state_d  = mem_ready ? FETCH : MEMWRITE;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          OpALU   = 2'b10;
          state_d = RWB;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          OpALU       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = ADDIWB;
        end
        ADDIWB: RegWrite = 1'b1;
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign pc_en = PCWrite | (PCWriteCond & zero);
  assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the
// FSM and compares state plus the full control vector every cycle.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst, pc_en, illegal;
  logic [1:0] PCSource, ALUSrcB, OpALU;
  logic [3:0] state;
  logic [17:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,RegWrite,RegDst,
  //  pc_en,PCSource[1:0],ALUSrcB[1:0],OpALU[1:0],illegal}
  localparam logic [17:0] V_NONE  = 18'b0000000000_0_00_00_00_0;
  localparam logic [17:0] V_FRDY  = 18'b1001010000_1_00_01_00_0;
  localparam logic [17:0] V_FSTL  = 18'b0001000000_0_00_01_00_0;
  localparam logic [17:0] V_DEC   = 18'b0000000000_0_00_11_00_0;
  localparam logic [17:0] V_DECIL = 18'b0000000000_0_00_11_00_1;
  localparam logic [17:0] V_MADR  = 18'b0000000100_0_00_10_00_0;
  localparam logic [17:0] V_MRD   = 18'b0011000000_0_00_00_00_0;
  localparam logic [17:0] V_MWR   = 18'b0010100000_0_00_00_00_0;
  localparam logic [17:0] V_MWB   = 18'b0000001010_0_00_00_00_0;
  localparam logic [17:0] V_EXEC  = 18'b0000000100_0_00_00_10_0;
  localparam logic [17:0] V_RWB   = 18'b0000000011_0_00_00_00_0;
  localparam logic [17:0] V_BR1   = 18'b0100000100_1_01_00_01_0;
  localparam logic [17:0] V_BR0   = 18'b0100000100_0_01_00_01_0;
  localparam logic [17:0] V_JMP   = 18'b1000000000_1_10_00_00_0;
  localparam logic [17:0] V_AWB   = 18'b0000000010_0_00_00_00_0;

  typedef struct packed {
    logic [5:0]  op;
    logic        mr;
    logic        z;
    logic [3:0]  st;
    logic [17:0] v;
  } step_t;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .pc_en(pc_en), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .OpALU(OpALU), .illegal(illegal), .state(state)
  );

  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 ALUSrcA, RegWrite, RegDst, pc_en, PCSource, ALUSrcB, OpALU, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = R;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (state !== 4'd0 || outs !== V_NONE) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: state=%0d outs=%b, want state=0 outs=%b",
                 i, state, outs, V_NONE);
      end
    end
    reset = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (state !== 4'd0 || outs !== V_FSTL) begin
        n_fail++;
        $display("FAIL fetch_stall cyc %0d: state=%0d outs=%b, want state=0 outs=%b",
                 i, state, outs, V_FSTL);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (outs !== V_FRDY) begin
      n_fail++;
      $display("FAIL fetch_ready: outs=%b, want %b", outs, V_FRDY);
    end
    tick();
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL fetch_to_decode: state=%0d, want 1", state);
    end
  endtask

  task automatic test_rtype();
    step_t seq[5];
    // opcode changes in EXEC/RWB must not affect the path
    seq = '{'{R, 1'b1, 1'b0, 4'd0, V_FRDY}, '{R, 1'b1, 1'b0, 4'd1, V_DEC},
            '{LW, 1'b1, 1'b0, 4'd6, V_EXEC}, '{SW, 1'b0, 1'b0, 4'd7, V_RWB},
            '{R, 1'b1, 1'b0, 4'd0, V_FRDY}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      opcode = seq[i].op; mem_ready = seq[i].mr; zero = seq[i].z;
      #1;
      n_checks++;
      if (state !== seq[i].st || outs !== seq[i].v) begin
        n_fail++;
        $display("FAIL rtype step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state, outs, seq[i].st, seq[i].v);
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    step_t seq[8];
    // mem_ready low in DECODE/MEMADR is ignored; low twice in MEMREAD stalls
    seq = '{'{LW, 1'b1, 1'b0, 4'd0, V_FRDY}, '{LW, 1'b0, 1'b0, 4'd1, V_DEC},
            '{LW, 1'b0, 1'b0, 4'd2, V_MADR}, '{LW, 1'b0, 1'b0, 4'd3, V_MRD},
            '{LW, 1'b0, 1'b0, 4'd3, V_MRD},  '{LW, 1'b1, 1'b0, 4'd3, V_MRD},
            '{LW, 1'b0, 1'b0, 4'd4, V_MWB},  '{LW, 1'b1, 1'b0, 4'd0, V_FRDY}};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      opcode = seq[i].op; mem_ready = seq[i].mr; zero = seq[i].z;
      #1;
      n_checks++;
      if (state !== seq[i].st || outs !== seq[i].v) begin
        n_fail++;
        $display("FAIL lw step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state, outs, seq[i].st, seq[i].v);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    step_t seq[7];
    seq = '{'{SW, 1'b0, 1'b0, 4'd0, V_FSTL}, '{SW, 1'b1, 1'b0, 4'd0, V_FRDY},
            '{SW, 1'b1, 1'b0, 4'd1, V_DEC},  '{SW, 1'b1, 1'b0, 4'd2, V_MADR},
            '{SW, 1'b0, 1'b0, 4'd5, V_MWR},  '{SW, 1'b1, 1'b0, 4'd5, V_MWR},
            '{SW, 1'b1, 1'b0, 4'd0, V_FRDY}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      opcode = seq[i].op; mem_ready = seq[i].mr; zero = seq[i].z;
      #1;
      n_checks++;
      if (state !== seq[i].st || outs !== seq[i].v) begin
        n_fail++;
        $display("FAIL sw step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state, outs, seq[i].st, seq[i].v);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    step_t seq[14];
    seq = '{'{BEQ, 1'b1, 1'b1, 4'd0, V_FRDY},   '{BEQ, 1'b1, 1'b1, 4'd1, V_DEC},
            '{BEQ, 1'b1, 1'b1, 4'd8, V_BR1},    '{BEQ, 1'b1, 1'b0, 4'd0, V_FRDY},
            '{BEQ, 1'b1, 1'b0, 4'd1, V_DEC},    '{BEQ, 1'b1, 1'b0, 4'd8, V_BR0},
            '{J, 1'b1, 1'b0, 4'd0, V_FRDY},     '{J, 1'b1, 1'b0, 4'd1, V_DEC},
            '{J, 1'b1, 1'b0, 4'd11, V_JMP},     '{ADDI, 1'b1, 1'b0, 4'd0, V_FRDY},
            '{ADDI, 1'b1, 1'b0, 4'd1, V_DEC},   '{ADDI, 1'b1, 1'b0, 4'd9, V_MADR},
            '{ADDI, 1'b1, 1'b0, 4'd10, V_AWB},  '{ADDI, 1'b1, 1'b0, 4'd0, V_FRDY}};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      opcode = seq[i].op; mem_ready = seq[i].mr; zero = seq[i].z;
      #1;
      n_checks++;
      if (state !== seq[i].st || outs !== seq[i].v) begin
        n_fail++;
        $display("FAIL b2b step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state, outs, seq[i].st, seq[i].v);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    step_t seq[4];
    seq = '{'{BAD, 1'b1, 1'b0, 4'd0, V_FRDY}, '{BAD, 1'b1, 1'b0, 4'd1, V_DECIL},
            '{BAD, 1'b1, 1'b0, 4'd0, V_FRDY}, '{BAD, 1'b1, 1'b0, 4'd1, V_DECIL}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      opcode = seq[i].op; mem_ready = seq[i].mr; zero = seq[i].z;
      #1;
      n_checks++;
      if (state !== seq[i].st || outs !== seq[i].v) begin
        n_fail++;
        $display("FAIL illegal step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state, outs, seq[i].st, seq[i].v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    opcode = LW; mem_ready = 1'b1; zero = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd3 || outs !== V_MRD) begin
      n_fail++;
      $display("FAIL midop_reach: state=%0d outs=%b, want state=3 outs=%b",
               state, outs, V_MRD);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'd0 || outs !== V_NONE) begin
      n_fail++;
      $display("FAIL midop_reset_comb: state=%0d outs=%b, want state=0 outs=%b",
               state, outs, V_NONE);
    end
    tick();
    n_checks++;
    if (state !== 4'd0 || outs !== V_NONE) begin
      n_fail++;
      $display("FAIL midop_reset_edge: state=%0d outs=%b, want state=0 outs=%b",
               state, outs, V_NONE);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || outs !== V_FSTL) begin
      n_fail++;
      $display("FAIL midop_after: state=%0d outs=%b, want state=0 outs=%b",
               state, outs, V_FSTL);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = R; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
